// File: rtl/spc_pkg.sv
// Shared definitions for the single-pixel counter path and the SPI readout block.
//   - default photon-count width and result FIFO depth
//   - window FSM state encoding
package spc_pkg;

  localparam int SPC_CNT_W      = 16;
  localparam int SPC_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } spc_state_e;

endpackage

// File: rtl/spc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered outputs.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write request and data; refused (drop=1) when full with no same-cycle pop
//   ready     : consumer accept; a pop happens when valid & ready
//   dout      : head word, registered; holds its last value while empty
//   valid     : FIFO non-empty
//   level     : number of stored words
//   drop      : combinational, a push was refused this cycle
module spc_sync_fifo
  import spc_pkg::*;
#(
  parameter int WIDTH = SPC_CNT_W,
  parameter int DEPTH = SPC_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     ready,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [LW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic             valid_q;
  logic             pop, full, push_ok;

  assign pop        = valid_q & ready;
  assign full       = (count == LW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok    = push & (~full | pop);
  assign drop       = push & full & ~pop;
  assign rd_ptr_inc = rd_ptr + PW'(1);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop) begin
      count_nxt = count + LW'(1);
    end else if (pop && !push_ok) begin
      count_nxt = count - LW'(1);
    end
  end

  // dout is a register, so the next head is selected ahead of time.
  always_comb begin
    dout_nxt = dout_q;
    if (pop) begin
      if (count > LW'(1)) begin
        dout_nxt = mem[rd_ptr_inc];
      end else if (push_ok) begin
        dout_nxt = din;
      end
    end else if ((count == '0) && push_ok) begin
      dout_nxt = din;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr_inc;
      count   <= count_nxt;
      dout_q  <= dout_nxt;
      valid_q <= (count_nxt != '0);
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign level = count;

endmodule

// File: rtl/photon_window_counter.sv
// Counts SPAD photon pulses while START_COUNT is high and commits each window
// total (one per DMD pattern) into a result FIFO drained over valid/ready.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   START_COUNT  : counting gate from the controller (CLK domain)
//   PHOTON_IN    : asynchronous SPAD pulse
//   CLEAR_FLAGS  : clears OVERFLOW and DROPPED
//   DATA_OUT     : head-of-FIFO window count
//   DATA_VALID   : FIFO non-empty
//   DATA_READY   : consumer accept
//   FIFO_LEVEL   : stored word count
//   BUSY         : window open or being committed
//   OVERFLOW     : sticky, a window count saturated
//   DROPPED      : sticky, a window total was lost to a full FIFO
//
// state     | meaning
// ST_IDLE   | gate closed, accumulator held at 0
// ST_COUNT  | gate open, counting photon edges
// ST_COMMIT | single cycle, window total pushed into the FIFO
module photon_window_counter
  import spc_pkg::*;
#(
  parameter int CNT_W       = SPC_CNT_W,
  parameter int FIFO_DEPTH  = SPC_FIFO_DEPTH,
  parameter int SYNC_STAGES = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START_COUNT,
  input  logic                          PHOTON_IN,
  input  logic                          CLEAR_FLAGS,
  output logic [CNT_W-1:0]              DATA_OUT,
  output logic                          DATA_VALID,
  input  logic                          DATA_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BUSY,
  output logic                          OVERFLOW,
  output logic                          DROPPED
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   ph_edge;
  spc_state_e             state, state_nxt;
  logic [CNT_W-1:0]       acc, acc_nxt;
  logic                   push, ovf_set, fifo_drop;
  logic                   busy_q, ovf_q, drop_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      ph_edge   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], PHOTON_IN};
      sync_prev <= sync_q[SYNC_STAGES-1];
      ph_edge   <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    push      = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_nxt = '0;
        if (START_COUNT) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        // The edge in the gate-closing cycle still belongs to this window.
        if (ph_edge) begin
          if (acc == ACC_MAX) ovf_set = 1'b1;
          else                acc_nxt = acc + CNT_W'(1);
        end
        if (!START_COUNT) state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        push      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        acc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      acc    <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      // Set events take priority over a coincident clear.
      if (ovf_set)          ovf_q <= 1'b1;
      else if (CLEAR_FLAGS) ovf_q <= 1'b0;
      if (fifo_drop)        drop_q <= 1'b1;
      else if (CLEAR_FLAGS) drop_q <= 1'b0;
    end
  end

  spc_sync_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   (acc),
    .ready (DATA_READY),
    .dout  (DATA_OUT),
    .valid (DATA_VALID),
    .level (FIFO_LEVEL),
    .drop  (fifo_drop)
  );

  assign BUSY     = busy_q;
  assign OVERFLOW = ovf_q;
  assign DROPPED  = drop_q;

endmodule
